fpu_dispatch: RTL

Issue/retire controller directly upstream of the fixed-point unit (ADD/SUB/MUL/SQRT, Q(WIDTH-FBITS).FBITS). It accepts one operation at a time from the execute stage over a valid/ready handshake and holds operands and opcode stable for the unit's multi-cycle operations. It captures the result on the unit's `ready` and presents it with its destination tag to writeback over a second valid/ready handshake. Between operations it drives the quiet opcode so the unit's internal MUL/SQRT sequencers return to stage 0.

---
 rtl/fpu_dispatch_pkg.sv | 24 ++
 rtl/fpu_dispatch_watchdog.sv | 30 +++
 rtl/fpu_dispatch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fpu_dispatch_pkg.sv
// Shared opcodes, state encoding and helpers for the fixed-point unit dispatcher.
// Opcode values mirror the FPU_* macros the fixed-point unit decodes.
package fpu_dispatch_pkg;

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;

   // FPU_ADD doubles as the quiet code that parks the unit's sequencers at stage 0
   localparam logic [1:0] FPU_QUIET = FPU_ADD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } dispatch_state_t;

   function automatic logic is_multicycle(input logic [1:0] op);
      return (op == FPU_MUL) || (op == FPU_SQRT);
   endfunction

endpackage

// File: rtl/fpu_dispatch_watchdog.sv
// WAIT-state cycle counter; flags expiry once TIMEOUT WAIT cycles elapse without a result.
// Only instantiated when FPU_DISPATCH_TIMEOUT_EN is defined.
module fpu_dispatch_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic active,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count;

   // Cleared on the edge that enters WAIT, so the first WAIT cycle reads 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (start) begin
         count <= '0;
      end else if (active) begin
         count <= count + 8'd1;
      end
   end

   assign expired = active && (count == LIMIT);

endmodule

// File: rtl/fpu_dispatch.sv
// Issue/retire controller in front of the fixed-point unit: one op in flight, result to writeback.
// Optional WAIT timeout with error response under FPU_DISPATCH_TIMEOUT_EN.
module fpu_dispatch
   import fpu_dispatch_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FBITS   = 10,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic [1:0]       fpu_operation,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_error,
   output logic             busy
);

   dispatch_state_t state, next_state;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, result_q;
   logic [TAG_W-1:0] tag_q;
   logic             error_q;

   logic capture, capture_error, timeout_hit, accept;

   logic unused_cfg;
   assign unused_cfg = ^{32'(FBITS), 32'(TIMEOUT)};

`ifdef FPU_DISPATCH_TIMEOUT_EN
   fpu_dispatch_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .start   ((state == ST_ISSUE) && is_multicycle(op_q)),
      .active  (state == ST_WAIT),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   assign accept = (state == ST_IDLE) && req_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ISSUE never samples fpu_ready: for MUL/SQRT it still reflects the unit's previous stage
   always_comb begin
      next_state    = state;
      capture       = 1'b0;
      capture_error = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (is_multicycle(op_q)) begin
               next_state = ST_WAIT;
            end else begin
               next_state = ST_RESP;
               capture    = 1'b1;
            end
         end
         ST_WAIT: begin
            if (fpu_ready) begin
               next_state = ST_RESP;
               capture    = 1'b1;
            end else if (timeout_hit) begin
               next_state    = ST_RESP;
               capture       = 1'b1;
               capture_error = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= FPU_QUIET;
         a_q      <= '0;
         b_q      <= '0;
         tag_q    <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            tag_q <= req_tag;
         end
         if (capture) begin
            result_q <= capture_error ? '0 : fpu_result;
            error_q  <= capture_error;
         end else if ((state == ST_RESP) && rsp_ready) begin
            error_q <= 1'b0;
         end
      end
   end

   // req_ready is a function of state and reset only, never of rsp_ready
   assign req_ready     = (state == ST_IDLE) && !reset;
   assign busy          = (state != ST_IDLE);
   assign fpu_operation = ((state == ST_ISSUE) || (state == ST_WAIT)) ? op_q : FPU_QUIET;
   assign fpu_operand_1 = a_q;
   assign fpu_operand_2 = b_q;
   assign rsp_valid     = (state == ST_RESP);
   assign rsp_result    = result_q;
   assign rsp_tag       = tag_q;
   assign rsp_error     = error_q;

endmodule
